// File: rtl/mult_pkg.sv
// Shared constants and operand-extension helper for the pipelined 64x64->128 multiplier.
package mult_pkg;
    localparam int OP_W           = 64;
    localparam int PROD_W         = 128;
    localparam int NUM_STAGES_DEF = 8;
    localparam int CHUNK_W        = PROD_W / NUM_STAGES_DEF;

    function automatic logic [PROD_W-1:0] ext_op(input logic [OP_W-1:0] op, input logic sgn);
        ext_op = sgn ? {{(PROD_W-OP_W){op[OP_W-1]}}, op} : {{(PROD_W-OP_W){1'b0}}, op};
    endfunction
endpackage

// File: rtl/mult_stage.sv
// One registered multiply stage: folds one multiplier chunk into the partial product.
// Latency 1 cycle; no backpressure, a new set of inputs is taken every cycle.
module mult_stage
    import mult_pkg::*;
#(
    parameter int CHUNK = CHUNK_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PROD_W-1:0] pp_in,
    input  logic [PROD_W-1:0] mcand_in,
    input  logic [PROD_W-1:0] mplier_in,
    input  logic              vld_in,
    output logic [PROD_W-1:0] pp_out,
    output logic [PROD_W-1:0] mcand_out,
    output logic [PROD_W-1:0] mplier_out,
    output logic              vld_out
);
    logic [PROD_W-1:0] pp_d, pp_q;
    logic [PROD_W-1:0] mcand_d, mcand_q;
    logic [PROD_W-1:0] mplier_d, mplier_q;
    logic              vld_d, vld_q;
    logic [PROD_W-1:0] chunk_ext;

    always_comb begin
        chunk_ext = '0;
        chunk_ext[CHUNK-1:0] = mplier_in[CHUNK-1:0];
        // Truncation to 128 bits is intentional: the result is modulo 2^128.
        pp_d     = pp_in + mcand_in * chunk_ext;
        mcand_d  = mcand_in << CHUNK;
        mplier_d = mplier_in >> CHUNK;
        vld_d    = vld_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pp_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            vld_q    <= 1'b0;
        end else begin
            pp_q     <= pp_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            vld_q    <= vld_d;
        end
    end

    assign pp_out     = pp_q;
    assign mcand_out  = mcand_q;
    assign mplier_out = mplier_q;
    assign vld_out    = vld_q;
endmodule

// File: rtl/mult.sv
// Fully pipelined 64x64 -> 128 multiplier with per-operand signedness.
// Latency NUM_STAGES cycles; accepts one operation per cycle, never stalls.
module mult
    import mult_pkg::*;
#(
    parameter int NUM_STAGES = NUM_STAGES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        sign,
    input  logic [OP_W-1:0]   mcand,
    input  logic [OP_W-1:0]   mplier,
    output logic [PROD_W-1:0] product,
    output logic              done
);
    // NUM_STAGES must divide 128 so every multiplier bit is consumed exactly once.
    localparam int CHUNK = PROD_W / NUM_STAGES;

    logic [NUM_STAGES:0][PROD_W-1:0] pp;
    logic [NUM_STAGES:0][PROD_W-1:0] mc;
    logic [NUM_STAGES:0][PROD_W-1:0] mp;
    logic [NUM_STAGES:0]             vld;
    logic                            unused_tail;

    assign pp[0]  = '0;
    assign mc[0]  = ext_op(mcand, sign[0]);
    assign mp[0]  = ext_op(mplier, sign[1]);
    assign vld[0] = start;

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        mult_stage #(.CHUNK(CHUNK)) u_stage (
            .clk        (clk),
            .reset      (reset),
            .pp_in      (pp[g]),
            .mcand_in   (mc[g]),
            .mplier_in  (mp[g]),
            .vld_in     (vld[g]),
            .pp_out     (pp[g+1]),
            .mcand_out  (mc[g+1]),
            .mplier_out (mp[g+1]),
            .vld_out    (vld[g+1])
        );
    end

    // Shifted operands leaving the final stage carry no further information.
    assign unused_tail = ^{mc[NUM_STAGES], mp[NUM_STAGES]};

    assign product = pp[NUM_STAGES];
    assign done    = vld[NUM_STAGES];
endmodule

// File: tb/tb_mult.sv
// Directed + random bench for mult with a scoreboard queue checked when done pulses.
module tb_mult;
    localparam int N = 8;

    typedef struct {
        logic [127:0] prod;
        int           issued;
        string        tag;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   sign;
    logic [63:0]  mcand;
    logic [63:0]  mplier;
    logic [127:0] product;
    logic         done;

    exp_t sbq[$];
    int   cycle   = 0;
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   n_done  = 0;
    int   n_issue = 0;

    mult #(.NUM_STAGES(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .sign    (sign),
        .mcand   (mcand),
        .mplier  (mplier),
        .product (product),
        .done    (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [127:0] model(input logic [1:0] s, input logic [63:0] a,
                                           input logic [63:0] b);
        logic signed [127:0] ea, eb;
        ea = s[0] ? 128'($signed(a)) : 128'({64'd0, a});
        eb = s[1] ? 128'($signed(b)) : 128'({64'd0, b});
        return 128'(ea * eb);
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding issue, in order, N cycles later.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            n_chk++;
            assert (sbq.size() != 0) n_pass++;
            else $error("FAIL unexpected_done observed=done expected=no_done cycle=%0d", cycle);
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk({e.tag, "_product"}, product, e.prod);
                chk({e.tag, "_latency"}, 128'(cycle - e.issued), 128'(N));
            end
        end
    end

    // Drives one operation for a single cycle, then scrambles the operands.
    task automatic issue(input logic [1:0] s, input logic [63:0] a, input logic [63:0] b,
                         input logic [127:0] exp, input string tag);
        exp_t e;
        start  = 1'b1;
        sign   = s;
        mcand  = a;
        mplier = b;
        e.prod = exp;
        e.issued = cycle;
        e.tag  = tag;
        sbq.push_back(e);
        n_issue++;
        @(posedge clk);
        #1;
        start  = 1'b0;
        sign   = 2'($urandom);
        mcand  = {$urandom, $urandom};
        mplier = {$urandom, $urandom};
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sbq.size() != 0; i++) @(posedge clk);
        #1;
        chk({tag, "_drained"}, 128'(sbq.size()), 128'd0);
        repeat (N + 2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0]  ra, rb;
        logic [1:0]   rs;
        int           done_before;

        reset = 1'b1; start = 1'b0; sign = 2'b00; mcand = '0; mplier = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_product", product, 128'd0);
        chk("reset_done", {127'd0, done}, 128'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        issue(2'b00, 64'd3, 64'd5, 128'd15, "unsigned_3x5");
        drain("unsigned");

        issue(2'b11, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, {{124{1'b1}}, 4'hA}, "signed_m2x3");
        issue(2'b00, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3,
              128'h2_FFFF_FFFF_FFFF_FFFA, "unsigned_fffex3");
        issue(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, "full_width");
        drain("sign_width");

        issue(2'b00, 64'd1, 64'd1, 128'd1, "b2b_0");
        issue(2'b00, 64'd2, 64'd3, 128'd6, "b2b_1");
        issue(2'b00, 64'd4, 64'd5, 128'd20, "b2b_2");
        issue(2'b00, 64'd7, 64'd7, 128'd49, "b2b_3");
        drain("back_to_back");

        issue(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, {{124{1'b1}}, 4'hE}, "mixed_01");
        issue(2'b10, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, {{124{1'b1}}, 4'h1}, "mixed_10");
        issue(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001, "mixed_01_max");
        drain("mixed");

        for (int i = 0; i < 12; i++) begin
            rs = 2'($urandom);
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            issue(rs, ra, rb, model(rs, ra, rb), $sformatf("rand%0d", i));
        end
        drain("random");

        // Reset mid-flight: the in-flight op and a start coincident with reset must vanish.
        done_before = n_done;
        issue(2'b00, 64'd9, 64'd9, 128'd81, "killed");
        @(posedge clk);
        #1;
        reset = 1'b1; start = 1'b1; sign = 2'b00; mcand = 64'd11; mplier = 64'd13;
        sbq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0; start = 1'b0; mcand = '0; mplier = '0;
        chk("midreset_product_now", product, 128'd0);
        chk("midreset_done_now", {127'd0, done}, 128'd0);
        repeat (N + 4) @(posedge clk);
        #1;
        chk("midreset_product_later", product, 128'd0);
        chk("midreset_no_done", 128'(n_done - done_before), 128'd0);

        issue(2'b11, 64'd6, 64'hFFFF_FFFF_FFFF_FFF9, {{122{1'b1}}, 6'b010110}, "post_reset");
        drain("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mult.md
MULT -- requirements
Module: mult

Interface
REQ-001 SHALL expose parameter NUM_STAGES, default 8, number of pipeline stages; 128 must be divisible by NUM_STAGES.
REQ-002 SHALL expose clk  input  1  rising-edge clock.
REQ-003 SHALL expose reset  input  1  synchronous, active-high reset.
REQ-004 SHALL expose start  input  1  operands valid this cycle; launches one multiply.
REQ-005 SHALL expose sign  input  2  sign[0]=1: mcand signed; sign[1]=1: mplier signed; 0 = unsigned.
REQ-006 SHALL expose mcand  input  64  multiplicand.
REQ-007 SHALL expose mplier  input  64  multiplier.
REQ-008 SHALL expose product  output  128  result, valid when done=1.
REQ-009 SHALL expose done  output  1  one-cycle pulse marking product valid for the matching start.

Function
REQ-010 SHALL extend each operand to 128 bits: sign-extend if its sign bit selects signed, else zero-extend.
REQ-011 SHALL compute product = low 128 bits of ext(mcand) * ext(mplier), two's-complement, with no saturation.
REQ-012 SHALL be fully pipelined with NUM_STAGES register stages; each stage consumes 128/NUM_STAGES (default 16) multiplier bits.
REQ-013 Each stage SHALL add (mcand_shifted * mplier_chunk) to the partial product, then shift mcand left and mplier right by the chunk width for the next stage.
REQ-014 Latency SHALL be exactly NUM_STAGES cycles: start sampled at edge k yields done=1 and valid product after edge k+NUM_STAGES.
REQ-015 SHALL accept a new start every cycle; results SHALL emerge in issue order, one per cycle, with no stalls.
REQ-016 done SHALL be start delayed by NUM_STAGES registers and SHALL be high for exactly one cycle per start.
REQ-017 Operands and sign SHALL be sampled only in the cycle start=1; changes afterward SHALL NOT affect in-flight results.
REQ-018 With start=0, stage contents are don't-care, but done SHALL stay 0 for that slot.
REQ-019 product SHALL hold the last stage's register contents; its value when done=0 is unspecified apart from reset.
REQ-020 There SHALL be no FSM; control SHALL be only the valid shift chain.

Reset
REQ-021 While reset=1 at a clock edge, all stage valid bits SHALL clear, making done=0 the following cycle.
REQ-022 Reset SHALL clear all partial-product and operand registers, making product=0 after reset.
REQ-023 A reset mid-operation SHALL discard all in-flight multiplies; no done pulse SHALL appear for any start issued before or during reset.
REQ-024 start asserted in the same cycle as reset SHALL be ignored.

Structure
REQ-025 A shared package SHALL hold NUM_STAGES default and the derived chunk width (128/NUM_STAGES).
REQ-026 SHALL use one sub-module, mult_stage: one registered stage taking partial product, mcand, mplier, and valid, and producing next partial product, shifted mcand, shifted mplier, and valid.
REQ-027 The top SHALL perform operand extension and instantiate NUM_STAGES mult_stage copies in a generate loop; the last stage SHALL drive product and done.

Verification
REQ-028 Unsigned: sign=00, mcand=3, mplier=5, start at edge 0 -> done=1 and product=15 after edge 8; done=0 elsewhere.
REQ-029 Signed: sign=11, mcand=-2 (64'hFFFF_FFFF_FFFF_FFFE), mplier=3 -> product=128'hFFFF...FFFA (-6). With sign=00 and the same inputs -> product=128'h2_FFFF_FFFF_FFFF_FFFA.
REQ-030 Full width: sign=00, mcand=mplier=64'hFFFF_FFFF_FFFF_FFFF -> product=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
REQ-031 Back-to-back: start on 4 consecutive cycles with pairs (1,1),(2,3),(4,5),(7,7) -> done high 4 consecutive cycles with products 1,6,20,49 in order.
REQ-032 Reset mid-flight: start at edge 0, reset at edge 3 -> done never pulses and product=0.
REQ-033 Mixed sign: sign=01 (mcand signed), mcand=-1, mplier=2 -> product=-2 in 128-bit two's complement.
